// File: rtl/irq_ctrl.sv
// Interrupt aggregator: pending/enable/mode registers, lowest-index priority, claim/complete FSM.
// Optional macro IRQ_CTRL_SYNC_EN adds a 2-flop synchroniser on every source line.
module irq_ctrl_src (
    input  logic clk,
    input  logic rst_n,
    input  logic src_irq,
    input  logic mode,
    input  logic clr,
    output logic pending
);
    logic src_s, src_q;

`ifdef IRQ_CTRL_SYNC_EN
    logic [1:0] sync;
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) sync <= '0;
        else       sync <= {sync[0], src_irq};
    end
    assign src_s = sync[1];
`else
    assign src_s = src_irq;
`endif

    // Edge mode: a new rising edge beats a same-cycle clear; level mode just follows the line.
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            src_q   <= 1'b0;
            pending <= 1'b0;
        end else begin
            src_q <= src_s;
            if (mode) pending <= (~src_q & src_s) | (pending & ~clr);
            else      pending <= src_s;
        end
    end
endmodule

module irq_ctrl #(
    parameter int NUM_SRC = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [3:0]         addr,
    input  logic               wr_en,
    input  logic               rd_en,
    input  logic [31:0]        wdata,
    output logic [31:0]        rdata,
    input  logic [NUM_SRC-1:0] src_irq,
    output logic               irq_out,
    output logic [3:0]         irq_id
);
    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_ASSERT  = 2'd1;
    localparam logic [1:0] ST_SERVICE = 2'd2;

    logic [NUM_SRC-1:0] pending, enable, mode, active, clr;
    logic [1:0]         state, next_state;
    logic [3:0]         claimed_id;
    logic [31:0]        claim_data;
    logic               wr_pend, wr_enab, wr_mode, claim_rd, claim_wr, claim_fire;
    logic               unused_wdata;

    assign unused_wdata = ^wdata;
    assign wr_pend    = wr_en && addr == 4'h0;
    assign wr_enab    = wr_en && addr == 4'h4;
    assign wr_mode    = wr_en && addr == 4'h8;
    assign claim_wr   = wr_en && addr == 4'hC;
    assign claim_rd   = rd_en && !wr_en && addr == 4'hC;
    assign active     = pending & enable;
    assign claim_fire = claim_rd && state == ST_ASSERT && |active;

    genvar i;
    generate
        for (i = 0; i < NUM_SRC; i++) begin : g_src
            assign clr[i] = (wr_pend & wdata[i]) | (claim_fire & (irq_id == 4'(i + 1)));
            irq_ctrl_src u_src (
                .clk     (clk),
                .rst_n   (rst_n),
                .src_irq (src_irq[i]),
                .mode    (mode[i]),
                .clr     (clr[i]),
                .pending (pending[i])
            );
        end
    endgenerate

    // Scan from the top so the lowest active index is the last one written.
    always_comb begin
        irq_id = 4'd0;
        for (int k = NUM_SRC - 1; k >= 0; k--)
            if (active[k]) irq_id = 4'(k + 1);
    end

    always_comb begin
        next_state = state;
        case (state)
            ST_IDLE:    if (|active) next_state = ST_ASSERT;
            ST_ASSERT:  if (!(|active)) next_state = ST_IDLE;
                        else if (claim_rd) next_state = ST_SERVICE;
            ST_SERVICE: if (claim_wr && wdata[3:0] == claimed_id) next_state = ST_IDLE;
            default:    next_state = ST_IDLE;
        endcase
    end

    always_comb begin
        claim_data = 32'd0;
        if (claim_fire)                claim_data = {1'b1, 27'd0, irq_id};
        else if (state == ST_SERVICE) claim_data = {28'd0, claimed_id};
    end

    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            state      <= ST_IDLE;
            irq_out    <= 1'b0;
            claimed_id <= 4'd0;
            enable     <= '0;
            mode       <= '0;
            rdata      <= 32'd0;
        end else begin
            state   <= next_state;
            irq_out <= (next_state == ST_ASSERT);
            if (claim_fire) claimed_id <= irq_id;
            if (wr_enab)    enable <= wdata[NUM_SRC-1:0];
            if (wr_mode)    mode   <= wdata[NUM_SRC-1:0];
            if (rd_en && !wr_en) begin
                case (addr)
                    4'h0:    rdata <= 32'(pending);
                    4'h4:    rdata <= 32'(enable);
                    4'h8:    rdata <= 32'(mode);
                    4'hC:    rdata <= claim_data;
                    default: rdata <= 32'd0;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_irq_ctrl.sv
// Scoreboard-driven bench for irq_ctrl: register reads checked against queued expectations.
module tb_irq_ctrl;
    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic [3:0]  addr = 4'h0;
    logic        wr_en = 1'b0;
    logic        rd_en = 1'b0;
    logic [31:0] wdata = 32'd0;
    logic [31:0] rdata;
    logic [3:0]  src_irq = 4'd0;
    logic        irq_out;
    logic [3:0]  irq_id;

    int          n_vec = 0;
    int          n_err = 0;
    logic [31:0] sb[$];
    logic [31:0] v, e;

    irq_ctrl #(.NUM_SRC(4)) dut (
        .clk(clk), .rst_n(rst_n), .addr(addr), .wr_en(wr_en), .rd_en(rd_en),
        .wdata(wdata), .rdata(rdata), .src_irq(src_irq), .irq_out(irq_out), .irq_id(irq_id)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b1; wr_en = 1'b0; rd_en = 1'b0; src_irq = 4'd0; addr = 4'h0; wdata = 32'd0;
        tick(); tick();
        rst_n = 1'b0;
        tick();
    endtask

    task automatic wr(input logic [3:0] a, input logic [31:0] d);
        addr = a; wdata = d; wr_en = 1'b1;
        tick();
        wr_en = 1'b0;
    endtask

    task automatic rd(input logic [3:0] a, output logic [31:0] d);
        addr = a; rd_en = 1'b1;
        tick();
        rd_en = 1'b0;
        d = rdata;
    endtask

    task automatic pulse(input logic [3:0] bits);
        src_irq = bits;
        tick();
        src_irq = 4'd0;
    endtask

    task automatic test_reset();
        rst_n = 1'b1;
        tick(); tick();
        n_vec++; if (rdata !== 32'd0) begin n_err++; $display("FAIL rst_rdata got %h exp 0", rdata); end
        n_vec++; if (irq_out !== 1'b0) begin n_err++; $display("FAIL rst_irq_out got %b exp 0", irq_out); end
        n_vec++; if (irq_id !== 4'd0) begin n_err++; $display("FAIL rst_irq_id got %0d exp 0", irq_id); end
        rst_n = 1'b0;
        tick();
        for (int k = 0; k < 3; k++) begin
            sb.push_back(32'd0);
            rd(4'(k * 4), v); e = sb.pop_front();
            n_vec++; if (v !== e) begin n_err++; $display("FAIL rst_reg%0d got %h exp %h", k, v, e); end
        end
    endtask

    task automatic test_edge_claim();
        do_reset();
        wr(4'h4, 32'h1); wr(4'h8, 32'h1);
        pulse(4'b0001);
        n_vec++; if (irq_out !== 1'b0) begin n_err++; $display("FAIL edge_early got %b exp 0", irq_out); end
        tick();
        n_vec++; if (irq_out !== 1'b1) begin n_err++; $display("FAIL edge_irq got %b exp 1", irq_out); end
        sb.push_back(32'h8000_0001);
        rd(4'hC, v); e = sb.pop_front();
        n_vec++; if (v !== e) begin n_err++; $display("FAIL edge_claim got %h exp %h", v, e); end
        n_vec++; if (irq_out !== 1'b0) begin n_err++; $display("FAIL edge_claim_irq got %b exp 0", irq_out); end
        sb.push_back(32'd0);
        rd(4'h0, v); e = sb.pop_front();
        n_vec++; if (v !== e) begin n_err++; $display("FAIL edge_pend got %h exp %h", v, e); end
        wr(4'hC, 32'h1);
        pulse(4'b0001);
        tick();
        n_vec++; if (irq_out !== 1'b1) begin n_err++; $display("FAIL edge_reraise got %b exp 1", irq_out); end
    endtask

    task automatic test_priority();
        do_reset();
        wr(4'h4, 32'h6); wr(4'h8, 32'h6);
        pulse(4'b0110);
        n_vec++; if (irq_id !== 4'd2) begin n_err++; $display("FAIL prio_id got %0d exp 2", irq_id); end
        tick();
        sb.push_back(32'h8000_0002);
        rd(4'hC, v); e = sb.pop_front();
        n_vec++; if (v !== e) begin n_err++; $display("FAIL prio_claim got %h exp %h", v, e); end
        wr(4'hC, 32'h2);
        n_vec++; if (irq_out !== 1'b0) begin n_err++; $display("FAIL prio_cmpl_irq got %b exp 0", irq_out); end
        tick();
        n_vec++; if (irq_id !== 4'd3) begin n_err++; $display("FAIL prio_id3 got %0d exp 3", irq_id); end
        n_vec++; if (irq_out !== 1'b1) begin n_err++; $display("FAIL prio_irq3 got %b exp 1", irq_out); end
    endtask

    task automatic test_mask_w1c();
        do_reset();
        wr(4'h8, 32'h1);
        pulse(4'b0001);
        tick();
        sb.push_back(32'h1);
        rd(4'h0, v); e = sb.pop_front();
        n_vec++; if (v !== e) begin n_err++; $display("FAIL mask_pend got %h exp %h", v, e); end
        n_vec++; if (irq_out !== 1'b0) begin n_err++; $display("FAIL mask_irq got %b exp 0", irq_out); end
        wr(4'h4, 32'h1);
        tick();
        n_vec++; if (irq_out !== 1'b1) begin n_err++; $display("FAIL unmask_irq got %b exp 1", irq_out); end
        wr(4'h0, 32'h1);
        tick();
        n_vec++; if (irq_out !== 1'b0) begin n_err++; $display("FAIL w1c_irq got %b exp 0", irq_out); end
        sb.push_back(32'h0);
        rd(4'h0, v); e = sb.pop_front();
        n_vec++; if (v !== e) begin n_err++; $display("FAIL w1c_pend got %h exp %h", v, e); end
    endtask

    task automatic test_level();
        do_reset();
        wr(4'h4, 32'h1);
        src_irq = 4'b0001;
        tick(); tick();
        n_vec++; if (irq_out !== 1'b1) begin n_err++; $display("FAIL lvl_irq got %b exp 1", irq_out); end
        sb.push_back(32'h8000_0001);
        rd(4'hC, v); e = sb.pop_front();
        n_vec++; if (v !== e) begin n_err++; $display("FAIL lvl_claim got %h exp %h", v, e); end
        sb.push_back(32'h1);
        rd(4'h0, v); e = sb.pop_front();
        n_vec++; if (v !== e) begin n_err++; $display("FAIL lvl_pend got %h exp %h", v, e); end
        src_irq = 4'd0;
        tick();
        wr(4'hC, 32'h1);
        tick();
        n_vec++; if (irq_out !== 1'b0) begin n_err++; $display("FAIL lvl_drop_irq got %b exp 0", irq_out); end
        n_vec++; if (irq_id !== 4'd0) begin n_err++; $display("FAIL lvl_drop_id got %0d exp 0", irq_id); end
    endtask

    task automatic test_boundaries();
        do_reset();
        wr(4'h4, 32'h1); wr(4'h8, 32'h1);
        pulse(4'b0001);
        tick();
        sb.push_back(32'h8000_0001);
        rd(4'hC, v); e = sb.pop_front();
        n_vec++; if (v !== e) begin n_err++; $display("FAIL bnd_claim got %h exp %h", v, e); end
        wr(4'hC, 32'h3);
        sb.push_back(32'h0000_0001);
        rd(4'hC, v); e = sb.pop_front();
        n_vec++; if (v !== e) begin n_err++; $display("FAIL bnd_wrong_id got %h exp %h", v, e); end
        wr(4'hC, 32'h1);
        sb.push_back(32'h0);
        rd(4'hC, v); e = sb.pop_front();
        n_vec++; if (v !== e) begin n_err++; $display("FAIL bnd_idle_claim got %h exp %h", v, e); end
        // W1C lands on the same edge as a fresh rising edge
        do_reset();
        wr(4'h8, 32'h1);
        src_irq = 4'b0001; addr = 4'h0; wdata = 32'h1; wr_en = 1'b1;
        tick();
        src_irq = 4'd0; wr_en = 1'b0;
        sb.push_back(32'h1);
        rd(4'h0, v); e = sb.pop_front();
        n_vec++; if (v !== e) begin n_err++; $display("FAIL bnd_w1c_set got %h exp %h", v, e); end
        // simultaneous read and write: write lands, rdata holds
        addr = 4'h4; wdata = 32'h1; wr_en = 1'b1; rd_en = 1'b1;
        tick();
        wr_en = 1'b0; rd_en = 1'b0;
        n_vec++; if (rdata !== 32'h1) begin n_err++; $display("FAIL bnd_rdwr_hold got %h exp 1", rdata); end
        sb.push_back(32'h1);
        rd(4'h4, v); e = sb.pop_front();
        n_vec++; if (v !== e) begin n_err++; $display("FAIL bnd_rdwr_en got %h exp %h", v, e); end
        // upper register bits ignore writes
        wr(4'h4, 32'hFFFF_FFF3);
        sb.push_back(32'h3);
        rd(4'h4, v); e = sb.pop_front();
        n_vec++; if (v !== e) begin n_err++; $display("FAIL bnd_upper got %h exp %h", v, e); end
    endtask

    task automatic test_reset_mid();
        do_reset();
        wr(4'h4, 32'h1); wr(4'h8, 32'h1);
        pulse(4'b0001);
        tick();
        n_vec++; if (irq_out !== 1'b1) begin n_err++; $display("FAIL mid_pre got %b exp 1", irq_out); end
        #2 rst_n = 1'b1;
        #1;
        n_vec++; if (irq_out !== 1'b0) begin n_err++; $display("FAIL mid_irq got %b exp 0", irq_out); end
        n_vec++; if (irq_id !== 4'd0) begin n_err++; $display("FAIL mid_id got %0d exp 0", irq_id); end
        tick();
        rst_n = 1'b0;
        tick();
    endtask

    initial begin
        test_reset();
        test_edge_claim();
        test_priority();
        test_mask_w1c();
        test_level();
        test_boundaries();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/irq_ctrl.md
# irq_ctrl

Interrupt aggregator that sits directly downstream of the timer and the other peripheral interrupt lines. It latches up to NUM_SRC request lines into a pending register, masks them, selects the highest-priority one and presents a single interrupt plus source ID to the CPU. It uses a claim/complete handshake over the same 4-bit address register bus as the peripherals.

## Interface
- NUM_SRC, 4: number of interrupt sources, 1..15; source IDs are 1..NUM_SRC, and ID 0 means "none".
- clk  input  1  system clock, all logic on rising edge.
- rst_n  input  1  reset; asynchronous, active-high.
- addr  input  4  register byte address: 0x0, 0x4, 0x8 or 0xC.
- wr_en  input  1  single-cycle write strobe.
- rd_en  input  1  single-cycle read strobe.
- wdata  input  32  write data.
- rdata  output  32  registered read data.
- src_irq  input  NUM_SRC  source request lines; bit i is ID i+1.
- irq_out  output  1  interrupt to the CPU, registered.
- irq_id  output  4  ID of the highest-priority enabled pending source; 0 when none.

## Operation
**Registers** (bits at and above NUM_SRC read 0 and ignore writes):
- 0x0 PENDING: read returns pending bits.
  - Write-1-to-clear applies to edge-mode bits only.
- 0x4 ENABLE: read/write mask.
- 0x8 MODE: read/write; 1 = edge (rising) mode, 0 = level mode.
- 0xC CLAIM:
  - Read returns {bit31 = valid, bits3:0 = id} and performs a claim.
  - Write of bits3:0 = id performs a complete.

**Pending update**, every cycle per bit i:
- Edge mode: set when src_q[i]=0 and src_s[i]=1; cleared by W1C or by a claim of that ID.
  - If set and clear occur in the same cycle, set wins.
- Level mode: pending[i] <= src_s[i]. W1C and claim have no effect.
- src_s is the (optionally synchronised) source; src_q is src_s delayed by one cycle.

**Priority**: lowest index wins. irq_id is combinational from pending & ENABLE.

**FSM** (state reg, reset to IDLE):
- IDLE → ASSERT when (pending & ENABLE) != 0.
- ASSERT → IDLE when (pending & ENABLE) == 0, e.g. source masked or W1C applied.
- ASSERT → SERVICE on CLAIM read:
  - captures irq_id into claimed_id;
  - returns valid=1 with that id;
  - clears the edge pending bit.
- SERVICE → IDLE on CLAIM write whose id equals claimed_id. A mismatched id is ignored.
- In SERVICE, a CLAIM read returns valid=0, id=claimed_id, with no state change. No nesting.
- In IDLE, a CLAIM read returns 0 with no state change.

**Outputs**:
- irq_out is registered as (next_state == ASSERT).
- wr_en and rd_en high together: the write executes and the read is ignored (rdata holds).

## Timing
- Reset values: rdata=0, irq_out=0, state=IDLE, PENDING/ENABLE/MODE/claimed_id=0, src_q=0. irq_id therefore reads 0.
- Register write takes effect at the clock edge where wr_en=1.
- rdata updates at the clock edge where rd_en=1 and holds until the next read.
- Edge latency, without sync: src rises before edge k → pending set at edge k → irq_out high after edge k+1.
- Level deassert: src falls → pending clears at the next edge → irq_out low one edge later, unless claimed.
- Claim read at edge k: irq_out low after edge k. It can reassert no earlier than one edge after the complete.
- Reset asserted mid-operation: immediate return to reset values. Pulses seen during reset are lost.

## Configuration
- IRQ_CTRL_SYNC_EN defined:
  - src_irq passes through a 2-flop synchroniser per bit before edge/level logic.
  - Adds 2 cycles to every source-to-pending latency.
  - Synchroniser flops reset to 0.
- IRQ_CTRL_SYNC_EN undefined: src_s = src_irq directly, and sources must be synchronous to clk.

## Test plan
- Reset: rst_n high 2 cycles → rdata=0, irq_out=0, irq_id=0. Reads of 0x0/0x4/0x8 return 0.
- Edge + claim/complete:
  - Setup: ENABLE=0x1, MODE=0x1; 1-cycle pulse on src_irq[0].
  - irq_out=1 two edges after the pulse; CLAIM read=0x8000_0001; PENDING=0; irq_out=0.
  - CLAIM write 1 → state IDLE; a second pulse re-raises irq_out.
- Priority:
  - Setup: ENABLE=0x6, MODE=0x6; pulse src bits 1 and 2 together.
  - irq_id=2; claim returns 0x8000_0002; after complete, irq_id=3 and irq_out=1.
- Masking and W1C:
  - Setup: MODE=0x1, ENABLE=0; pulse src0 → PENDING=0x1, irq_out=0.
  - Write ENABLE=1 → irq_out=1. Write PENDING=1 → irq_out=0.
- Level mode:
  - Setup: MODE=0, ENABLE=0x1; hold src0 high → irq_out=1.
  - Claim returns 0x8000_0001; PENDING stays 1.
  - Drop src0, then complete with id 1 → irq_out stays 0.
- Boundaries:
  - Complete with wrong id 3 → stays in SERVICE, second claim returns 0x0000_0001.
  - W1C in the same cycle as a new edge → pending stays 1.
